// File: rtl/pll_lock_ctrl.sv
// ============================================================================
// Module   : pll_lock_ctrl
// Purpose  : PLL bring-up sequencer: reset pulse, lock wait with retries,
//            stabilisation window, run-time lock monitoring and fault hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       ready,
    output logic       sys_rst_n,
    output logic       fault,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_o
);

    localparam int C_CNT_MAX =
        (RST_CYCLES > LOCK_TIMEOUT) ?
            ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES) :
            ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int C_CNT_W = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_RST_LAST    = C_CNT_W'(RST_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_LOCK_LAST   = C_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0] C_STABLE_LAST = C_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]         C_RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q;
    logic                 locked_s_q;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]           retry_q, retry_d;
    logic [7:0]           loss_cnt_q, loss_cnt_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        retry_d    = retry_q;
        loss_cnt_d = loss_cnt_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == C_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == C_LOCK_LAST) begin
                    retry_d = retry_q + 4'd1;
                    state_d = ((retry_q + 4'd1) == C_RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == C_STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // A lock loss wins over a coincident relock request so it is counted.
                if (!locked_s_q) begin
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                    state_d = ST_RESET_PLL;
                end else if (relock_req) begin
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
                if (relock_req) begin
                    retry_d = 4'd0;
                    state_d = ST_RESET_PLL;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs decode the next state so they change on the same edge as state_o.
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET_PLL;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            cnt_q      <= '0;
            retry_q    <= 4'd0;
            loss_cnt_q <= 8'd0;
            pll_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            loss_cnt_q <= loss_cnt_d;
            pll_rst_q  <= pll_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign ready         = ready_q;
    assign sys_rst_n     = ready_q;
    assign fault         = fault_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
// ============================================================================
// Module   : tb_pll_lock_ctrl
// Purpose  : Scoreboard bench for pll_lock_ctrl driven by a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       ready;
    logic       sys_rst_n;
    logic       fault;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_o;
    logic [14:0] dut_vec;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] sb_q[$];

    int   m_state;
    int   m_cyc;
    int   m_retry;
    int   m_llc;
    logic m_s1;
    logic m_s2;

    int first_run;
    int n_steps;
    int stab_cnt;
    int wait_cnt;
    int wait_visits;
    int prev_state;

    pll_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .ready        (ready),
        .sys_rst_n    (sys_rst_n),
        .fault        (fault),
        .lock_loss_cnt(lock_loss_cnt),
        .state_o      (state_o)
    );

    always #20 refclk = ~refclk;

    assign dut_vec = {state_o, pll_rst, ready, sys_rst_n, fault, lock_loss_cnt};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [14:0] model_vec();
        logic run_s;
        run_s = (m_state == 3);
        return {3'(m_state), (m_state == 0) || (m_state == 4), run_s, run_s,
                (m_state == 4), 8'(m_llc)};
    endfunction

    task automatic model_go(input int s);
        m_state = s;
        m_cyc   = 0;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cyc   = 0;
        m_retry = 0;
        m_llc   = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endtask

    // One rising edge of the reference behaviour; the FSM sees the old locked_s.
    task automatic model_edge(input logic lk, input logic rq);
        case (m_state)
            0: if (m_cyc + 1 == RST_CYCLES) model_go(1); else m_cyc++;
            1: begin
                if (m_s2) model_go(2);
                else if (m_cyc + 1 == LOCK_TIMEOUT) begin
                    m_retry++;
                    model_go((m_retry == MAX_RETRY) ? 4 : 0);
                end else m_cyc++;
            end
            2: begin
                if (!m_s2) model_go(1);
                else if (m_cyc + 1 == STABLE_CYCLES) begin
                    m_retry = 0;
                    model_go(3);
                end else m_cyc++;
            end
            3: begin
                if (!m_s2) begin
                    m_llc = (m_llc < 255) ? m_llc + 1 : 255;
                    model_go(0);
                end else if (rq) model_go(0);
            end
            default: begin
                if (rq) begin
                    m_retry = 0;
                    model_go(0);
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = lk;
    endtask

    task automatic step(input logic lk, input logic rq);
        pll_locked = lk;
        relock_req = rq;
        model_edge(lk, rq);
        sb_q.push_back(model_vec());
        @(posedge refclk);
        #1;
        check_eq("outs", 32'(dut_vec), 32'(sb_q.pop_front()));
        check_eq("retry", 32'(dut.retry_q), m_retry);
        relock_req = 1'b0;
    endtask

    task automatic check_reset_values();
        check_eq("rst_outs", 32'(dut_vec), 32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        check_eq("rst_retry", 32'(dut.retry_q), 0);
        check_eq("rst_cnt", 32'(dut.cnt_q), 0);
        check_eq("rst_sync", 32'({dut.sync1_q, dut.locked_s_q}), 0);
    endtask

    task automatic wait_ready(input int max_steps);
        int n;
        n = 0;
        while (!ready && n < max_steps) begin
            step(1'b1, 1'b0);
            n++;
        end
        check_eq("reach_run", 32'(ready), 1);
    endtask

    task automatic loss_with_relock();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        check_reset_values();

        // Bring-up: lock appears at the start of WAIT_LOCK, RUN expected at cycle 15.
        rst_n     = 1'b1;
        first_run = -1;
        for (int i = 0; i < 30 && first_run < 0; i++) begin
            step(i >= 4, 1'b0);
            if (ready) first_run = i + 1;
        end
        check_eq("bringup_run_cycle", first_run, 15);
        check_eq("bringup_sys_rst_n", 32'(sys_rst_n), 1);
        check_eq("bringup_llc", 32'(lock_loss_cnt), 0);

        // Single-cycle lock loss in RUN.
        step(1'b0, 1'b0);
        check_eq("loss_ready_e1", 32'(ready), 1);
        step(1'b1, 1'b0);
        check_eq("loss_ready_e2", 32'(ready), 1);
        step(1'b1, 1'b0);
        check_eq("loss_ready_e3", 32'(ready), 0);
        check_eq("loss_state", 32'(state_o), 0);
        wait_ready(60);
        check_eq("loss_cnt", 32'(lock_loss_cnt), 1);

        // Relock request while locked, then a glitch in STABILIZE cycle 5.
        step(1'b1, 1'b1);
        check_eq("relock_state", 32'(state_o), 0);
        check_eq("relock_cnt", 32'(lock_loss_cnt), 1);
        n_steps = 0;
        while (state_o != 3'd2 && n_steps < 20) begin
            step(1'b1, 1'b0);
            n_steps++;
        end
        check_eq("reach_stab", 32'(state_o), 2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("glitch_state", 32'(state_o), 1);
        check_eq("glitch_retry", 32'(dut.retry_q), 0);
        stab_cnt = 0;
        n_steps  = 0;
        while (!ready && n_steps < 40) begin
            step(1'b1, 1'b0);
            if (state_o == 3'd2) stab_cnt++;
            n_steps++;
        end
        check_eq("restab_cycles", stab_cnt, 8);

        // Timeout path: lock never returns after a relock.
        step(1'b0, 1'b1);
        wait_cnt    = 0;
        wait_visits = 0;
        prev_state  = 0;
        n_steps     = 0;
        while (state_o != 3'd4 && n_steps < 200) begin
            step(1'b0, 1'b0);
            if (state_o == 3'd1) begin
                wait_cnt++;
                if (prev_state != 1) wait_visits++;
            end
            prev_state = int'(state_o);
            n_steps++;
        end
        check_eq("to_wait_cycles", wait_cnt, 40);
        check_eq("to_visits", wait_visits, 2);
        check_eq("to_state", 32'(state_o), 4);
        check_eq("to_fault", 32'(fault), 1);
        check_eq("to_pll_rst", 32'(pll_rst), 1);
        step(1'b0, 1'b0);
        check_eq("fault_hold", 32'(state_o), 4);
        step(1'b0, 1'b1);
        check_eq("fault_exit_state", 32'(state_o), 0);
        check_eq("fault_exit_retry", 32'(dut.retry_q), 0);
        wait_ready(80);

        // Relock request coincident with lock loss counts as a loss; then saturation.
        loss_with_relock();
        check_eq("simul_state", 32'(state_o), 0);
        check_eq("simul_cnt", 32'(lock_loss_cnt), 2);
        for (int k = 0; k < 256; k++) begin
            wait_ready(80);
            loss_with_relock();
        end
        check_eq("sat_cnt", 32'(lock_loss_cnt), 255);

        // Asynchronous reset in the middle of a RUN cycle.
        wait_ready(80);
        #10;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        check_eq("async_sys_rst_n", 32'(sys_rst_n), 0);
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        wait_ready(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
